// File: rtl/motion_pkg.sv
// Shared types and default sizing for the motion-detection datapath.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    localparam int unsigned PIX_W_DEFAULT        = 24;
    localparam int unsigned FRAME_PIXELS_DEFAULT = 768 * 576;

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame pixel counter: synchronous clear, increment, holds at MAX_COUNT.
module frame_pixel_counter #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] TERMINAL = W'(MAX_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != TERMINAL) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/subtract_arbiter.sv
// Frame-level round-robin arbiter sharing one subtract stage between two camera channels.
// Optional statistics outputs are enabled by defining SUBTRACT_ARBITER_STATS_EN.
module subtract_arbiter
    import motion_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int unsigned PIX_W        = PIX_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    output logic             ch0_bg_rd_en,
    input  logic             ch0_bg_empty,
    input  logic [PIX_W-1:0] ch0_bg_dout,
    output logic             ch0_fr_rd_en,
    input  logic             ch0_fr_empty,
    input  logic [PIX_W-1:0] ch0_fr_dout,
    output logic             ch0_out_wr_en,
    input  logic             ch0_out_full,
    output logic [PIX_W-1:0] ch0_out_din,
    output logic             ch1_bg_rd_en,
    input  logic             ch1_bg_empty,
    input  logic [PIX_W-1:0] ch1_bg_dout,
    output logic             ch1_fr_rd_en,
    input  logic             ch1_fr_empty,
    input  logic [PIX_W-1:0] ch1_fr_dout,
    output logic             ch1_out_wr_en,
    input  logic             ch1_out_full,
    output logic [PIX_W-1:0] ch1_out_din,
    input  logic             sub_bg_rd_en,
    output logic             sub_bg_empty,
    output logic [PIX_W-1:0] sub_bg_dout,
    input  logic             sub_fr_rd_en,
    output logic             sub_fr_empty,
    output logic [PIX_W-1:0] sub_fr_dout,
    input  logic             sub_out_wr_en,
    output logic             sub_out_full,
    input  logic [PIX_W-1:0] sub_out_din,
    output logic             grant,
    output logic             busy,
    output logic             frame_done
`ifdef SUBTRACT_ARBITER_STATS_EN
    ,
    output logic [15:0]      ch0_frames,
    output logic [15:0]      ch1_frames,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int unsigned  CNT_W    = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(FRAME_PIXELS);

    arb_state_t       state;
    logic             last_grant;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             in_tc;
    logic             out_tc;
    logic [1:0]       bg_empty;
    logic [1:0]       fr_empty;
    logic [1:0]       out_full;
    logic [1:0]       ready;
    logic [1:0]       bg_rd_en;
    logic [1:0]       fr_rd_en;
    logic [1:0]       out_wr_en;
    logic             muxed;

    assign bg_empty = {ch1_bg_empty, ch0_bg_empty};
    assign fr_empty = {ch1_fr_empty, ch0_fr_empty};
    assign out_full = {ch1_out_full, ch0_out_full};
    assign ready    = ~bg_empty & ~fr_empty;
    assign in_tc    = (in_cnt == TERMINAL);
    assign out_tc   = (out_cnt == TERMINAL);
    assign muxed    = (state != IDLE);

    frame_pixel_counter #(.MAX_COUNT(FRAME_PIXELS), .W(CNT_W)) u_in_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .inc   (busy && sub_bg_rd_en),
        .count (in_cnt)
    );

    frame_pixel_counter #(.MAX_COUNT(FRAME_PIXELS), .W(CNT_W)) u_out_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .inc   (busy && sub_out_wr_en),
        .count (out_cnt)
    );

    // Input side is only connected while streaming; output side stays muxed through DRAIN.
    always_comb begin
        sub_bg_empty = 1'b1;
        sub_fr_empty = 1'b1;
        sub_out_full = 1'b1;
        sub_bg_dout  = '0;
        sub_fr_dout  = '0;
        bg_rd_en     = '0;
        fr_rd_en     = '0;
        out_wr_en    = '0;
        if (state == STREAM) begin
            sub_bg_empty     = bg_empty[grant] | in_tc;
            sub_fr_empty     = fr_empty[grant] | in_tc;
            sub_bg_dout      = grant ? ch1_bg_dout : ch0_bg_dout;
            sub_fr_dout      = grant ? ch1_fr_dout : ch0_fr_dout;
            bg_rd_en[grant]  = sub_bg_rd_en;
            fr_rd_en[grant]  = sub_fr_rd_en;
        end
        if (muxed) begin
            sub_out_full     = out_full[grant];
            out_wr_en[grant] = sub_out_wr_en;
        end
    end

    assign ch0_bg_rd_en  = bg_rd_en[0];
    assign ch0_fr_rd_en  = fr_rd_en[0];
    assign ch0_out_wr_en = out_wr_en[0];
    assign ch1_bg_rd_en  = bg_rd_en[1];
    assign ch1_fr_rd_en  = fr_rd_en[1];
    assign ch1_out_wr_en = out_wr_en[1];
    assign ch0_out_din   = (muxed && !grant) ? sub_out_din : '0;
    assign ch1_out_din   = (muxed &&  grant) ? sub_out_din : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready[~last_grant]) begin
                        grant <= ~last_grant;
                        busy  <= 1'b1;
                        state <= STREAM;
                    end else if (ready[last_grant]) begin
                        grant <= last_grant;
                        busy  <= 1'b1;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_tc) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_tc) begin
                        last_grant <= grant;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUBTRACT_ARBITER_STATS_EN
    logic stall;

    // Input emptiness only counts while more pixels of the frame are still wanted.
    always_comb begin
        stall = busy && (out_full[grant] ||
                (state == STREAM && !in_tc && (bg_empty[grant] || fr_empty[grant])));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch0_frames   <= '0;
            ch1_frames   <= '0;
            stall_cycles <= '0;
        end else begin
            if (frame_done) begin
                if (grant) begin
                    ch1_frames <= ch1_frames + 16'd1;
                end else begin
                    ch0_frames <= ch0_frames + 16'd1;
                end
            end
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/subtract_arbiter.md
Name: subtract_arbiter

Overview:
- Frame-level round-robin arbiter sharing one `subtract` datapath between two camera channels.
- Each channel owns its own background FIFO, frame FIFO and mask output FIFO.
- The arbiter grants one channel for a whole frame (FRAME_PIXELS pixel pairs) and muxes that channel's FIFO handshakes to and from the subtract stage.
- It drains the in-flight result before switching channels, so masks never interleave within a frame.

Parameters:
- FRAME_PIXELS, 768*576: pixels per frame, i.e. pixel pairs read and results written per grant.
- PIX_W, 24: pixel and mask data width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- ch0_bg_rd_en  out  1  ch0 background FIFO read
- ch0_bg_empty  in  1  ch0 background FIFO empty
- ch0_bg_dout  in  PIX_W  ch0 background pixel
- ch0_fr_rd_en  out  1  ch0 frame FIFO read
- ch0_fr_empty  in  1  ch0 frame FIFO empty
- ch0_fr_dout  in  PIX_W  ch0 frame pixel
- ch0_out_wr_en  out  1  ch0 mask FIFO write
- ch0_out_full  in  1  ch0 mask FIFO full
- ch0_out_din  out  PIX_W  ch0 mask data
- ch1_*  same nine ports as ch0_* for channel 1
- sub_bg_rd_en  in  1  from subtract
- sub_bg_empty  out  1  to subtract
- sub_bg_dout  out  PIX_W  to subtract
- sub_fr_rd_en  in  1  from subtract
- sub_fr_empty  out  1  to subtract
- sub_fr_dout  out  PIX_W  to subtract
- sub_out_wr_en  in  1  from subtract
- sub_out_full  out  1  to subtract
- sub_out_din  in  PIX_W  from subtract
- grant  out  1  channel currently owning subtract
- busy  out  1  high in STREAM/DRAIN
- frame_done  out  1  one-cycle pulse after the last mask write of a frame

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so ch0 is served first).
  - in_cnt=0, out_cnt=0, busy=0, frame_done=0.
  - All channel rd_en/wr_en=0, all ch*_out_din=0.
  - sub_bg_empty=sub_fr_empty=sub_out_full=1, sub data=0.
- Counters: in_cnt and out_cnt are $clog2(FRAME_PIXELS+1) bits and never wrap.
  - in_cnt increments on sub_bg_rd_en while busy.
  - out_cnt increments on sub_out_wr_en while busy.
- IDLE:
  - A channel is ready when its bg_empty=0 and fr_empty=0.
  - Candidate order is ~last_grant first, then last_grant.
  - The first ready candidate is registered into grant; in_cnt and out_cnt clear; go to STREAM.
  - Nothing ready: stay in IDLE.
  - The subtract stage sees empties and full asserted throughout IDLE.
- STREAM, combinational pass-through for the granted channel:
  - sub_bg_empty = chG_bg_empty OR (in_cnt==FRAME_PIXELS), and likewise for fr.
  - sub_*_dout = chG_*_dout.
  - chG_bg_rd_en = sub_bg_rd_en; chG_fr_rd_en = sub_fr_rd_en.
  - sub_out_full = chG_out_full.
  - chG_out_wr_en = sub_out_wr_en; chG_out_din = sub_out_din.
  - The non-granted channel's rd_en/wr_en stay 0 and its data is ignored; no combinational leakage between channels.
  - When in_cnt reaches FRAME_PIXELS, go to DRAIN.
- DRAIN:
  - Input empties stay forced high, so no further reads occur; the output path stays muxed.
  - When out_cnt reaches FRAME_PIXELS:
    - last_grant <= grant, busy <= 0.
    - frame_done pulses for 1 cycle.
    - Return to IDLE.
- Latency: IDLE to STREAM takes 1 cycle after readiness. At least 1 idle cycle separates consecutive frames.
- Boundary conditions:
  - Granted FIFO empty or full mid-frame: stall in place; counters hold.
  - Other channel becomes ready mid-frame: ignored until IDLE.
  - Both channels ready at once: ~last_grant wins; consecutive frames alternate.
  - A read and a write in the same cycle: both counters advance.
  - Reset mid-frame: the frame is abandoned and all state returns to reset values. FIFO contents are untouched; resynchronising the FIFOs is the system's responsibility.
  - FRAME_PIXELS=1 is legal.

Optional Feature:
- Macro SUBTRACT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs ch0_frames and ch1_frames, each 16 bits, wrapping.
  - Each increments on the frame_done of its own channel; reset to 0.
  - Adds stall_cycles (32 bits, saturating): counts STREAM/DRAIN cycles where the granted FIFO is empty or the granted out FIFO is full.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package motion_pkg:
  - arb_state_t enum {IDLE, STREAM, DRAIN}, 2 bits.
  - PIX_W_DEFAULT=24.
  - FRAME_PIXELS_DEFAULT=768*576.
- Sub-module frame_pixel_counter: parameterised clear/increment/terminal-count counter, instantiated twice (in_cnt, out_cnt).

Test Plan:
- Use FRAME_PIXELS=4 throughout.
- Only ch0 loaded with 4 pairs: 4 ch0 reads → 4 ch0 mask writes → frame_done 1 pulse; ch1 rd_en/wr_en never high.
- Both channels loaded with 8 pairs: grant sequence 0,1,0,1; each frame exactly 4 writes to the matching out FIFO; no interleave.
- ch0 out_full held high for 10 cycles after the 2nd write: reads stall after 1 extra pixel, no write to ch1, frame completes after release.
- ch1 becomes ready during ch0's DRAIN: grant changes only after frame_done; ch1 serviced next.
- Reset asserted after 2 reads: busy=0, grant=0, sub empties=1 on the next edge; after release ch0 is granted again with counters at 0.
- With SUBTRACT_ARBITER_STATS_EN: 3 alternating frames → ch0_frames=2, ch1_frames=1; stall_cycles equals the injected empty cycles.
